// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: cycles one digit per SCAN_DIV clocks,
// double-buffers the display contents and applies leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DS_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_all,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            num,
  output logic                  dp,
  output logic [DIGITS-1:0]     DS,
  output logic                  scan_tick,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [15:0]       PRESC_LAST = 16'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DS_OFF     = {DIGITS{DS_ACTIVE_LOW}};

  logic [15:0]         presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] act_data;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;
  logic                en_d;

  logic                slot_end;
  logic                frame_wrap;
  logic                commit;

  logic [DIGITS-1:0]   hi_zero;
  logic                zero_run;
  logic [3:0]          nibble;
  logic                cur_dp;
  logic                lead_zero;
  logic [DIGITS-1:0]   sel;
  logic [6:0]          seg_on;
  logic [6:0]          num_next;
  logic                dp_next;
  logic [DIGITS-1:0]   ds_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A fresh enable counts as a frame boundary so pending data shows immediately.
  always_comb begin
    slot_end   = en_all && (presc == PRESC_LAST);
    frame_wrap = slot_end && (idx == IDX_LAST);
    commit     = pend_valid && en_all && (frame_wrap || !en_d);
  end

  // hi_zero[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    hi_zero  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (act_data[4*i +: 4] == 4'h0);
      hi_zero[i] = zero_run;
    end
  end

  always_comb begin
    nibble    = 4'h0;
    cur_dp    = 1'b0;
    lead_zero = 1'b0;
    sel       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble    = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        lead_zero = (i != 0) && hi_zero[i];
        sel[i]    = 1'b1;
      end
    end
    seg_on   = (LZ_BLANK && lead_zero) ? 7'h00 : hex7(nibble);
    num_next = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    dp_next  = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
    ds_next  = DS_ACTIVE_LOW ? ~sel : sel;
  end

  // Outputs lag the index by one cycle; load is honoured even while dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      en_d       <= 1'b0;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
      num        <= SEG_OFF;
      dp         <= DP_OFF;
      DS         <= DS_OFF;
    end else begin
      en_d <= en_all;

      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (load)
        pend_valid <= 1'b1;
      else if (commit)
        pend_valid <= 1'b0;
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end

      if (!en_all) begin
        presc      <= '0;
        idx        <= '0;
        scan_tick  <= 1'b0;
        frame_done <= 1'b0;
        num        <= SEG_OFF;
        dp         <= DP_OFF;
        DS         <= DS_OFF;
      end else begin
        presc      <= slot_end ? 16'd0 : presc + 16'd1;
        scan_tick  <= slot_end;
        frame_done <= frame_wrap;
        if (slot_end)
          idx <= frame_wrap ? '0 : idx + 1'b1;
        num <= num_next;
        dp  <= dp_next;
        DS  <= ds_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic checked
// against a timeline model of the scan and the double buffer.
module tb_seg_scan_ctrl;

  localparam int DG = 8;
  localparam int SD = 4;
  localparam int FR = DG * SD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_all, load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [6:0]  num;
  logic        dp;
  logic [7:0]  ds;
  logic        scan_tick, frame_done;

  logic        en2, load2;
  logic [15:0] data2;
  logic [3:0]  dp2_in;
  logic [6:0]  num2;
  logic        dp2;
  logic [3:0]  ds2;
  logic        tick2, fd2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: run = enabled edges since scan start; buffers kept as plain words.
  int          run;
  logic        prev_en, pv;
  logic [31:0] act_d, pend_d;
  logic [7:0]  act_dp, pend_dp;
  logic [6:0]  exp_num;
  logic        exp_dp;
  logic [7:0]  exp_ds;
  logic        exp_tick, exp_fd;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DS_ACTIVE_LOW(1'b1),
                  .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .en_all(en_all), .load(load), .data_in(data_in), .dp_in(dp_in),
    .num(num), .dp(dp), .DS(ds), .scan_tick(scan_tick), .frame_done(frame_done));

  seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .DS_ACTIVE_LOW(1'b1),
                  .LZ_BLANK(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en_all(en2), .load(load2), .data_in(data2), .dp_in(dp2_in),
    .num(num2), .dp(dp2), .DS(ds2), .scan_tick(tick2), .frame_done(fd2));

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    int d;
    logic commit;
    logic [3:0] nib;
    @(posedge clk);
    commit = 1'b0;
    if (rst) begin
      run = 0; prev_en = 1'b0; pv = 1'b0;
      act_d = '0; pend_d = '0; act_dp = '0; pend_dp = '0;
      exp_num = 7'h7F; exp_dp = 1'b1; exp_ds = 8'hFF; exp_tick = 1'b0; exp_fd = 1'b0;
    end else begin
      if (!en_all) begin
        run = 0;
        exp_num = 7'h7F; exp_dp = 1'b1; exp_ds = 8'hFF; exp_tick = 1'b0; exp_fd = 1'b0;
      end else begin
        d   = (run / SD) % DG;
        nib = 4'((act_d >> (4 * d)) & 32'hF);
        if (d > 0 && (act_d >> (4 * d)) == 32'd0) exp_num = 7'h7F;
        else exp_num = ~seg_tab[nib];
        exp_dp = ~act_dp[d];
        exp_ds = ~(8'd1 << d);
        commit = pv && (!prev_en || ((run + 1) % FR == 0));
        if (commit) begin act_d = pend_d; act_dp = pend_dp; end
        run++;
        exp_tick = (run % SD == 0);
        exp_fd   = (run % FR == 0);
      end
      if (load) begin pend_d = data_in; pend_dp = dp_in; pv = 1'b1; end
      else if (commit) pv = 1'b0;
      prev_en = en_all;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en_all = 1'b1; load = 1'b1; data_in = 32'hFFFF_FFFF; dp_in = 8'hFF;
    step();
    n_checks++;
    if ({num, dp, ds, scan_tick, frame_done} !== {7'h7F, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got num=%h dp=%b DS=%h tick=%b fd=%b, want 7f 1 ff 0 0",
               num, dp, ds, scan_tick, frame_done);
    end
    rst = 1'b0; load = 1'b0; dp_in = '0;
    step();
    n_checks++;
    if ({ds, num, dp} !== {8'hFE, 7'h40, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_load_ignored: got DS=%h num=%h dp=%b, want fe 40 1", ds, num, dp);
    end
    step();
    n_checks++;
    if ({num, dp, ds, scan_tick, frame_done} !== {exp_num, exp_dp, exp_ds, exp_tick, exp_fd}) begin
      n_fail++;
      $display("[TB] FAIL reset_release_model: got %h/%b/%h/%b/%b, want %h/%b/%h/%b/%b",
               num, dp, ds, scan_tick, frame_done, exp_num, exp_dp, exp_ds, exp_tick, exp_fd);
    end
  endtask

  task automatic test_display();
    int w;
    logic [6:0] en_exp;
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1; load = 1'b1; data_in = 32'h0000_0012; dp_in = '0;
    step();
    load = 1'b0;
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL display_frame_wait: got fd=%b, want 1", frame_done);
    end
    step();
    for (int k = 0; k < DG; k++) begin
      en_exp = (k == 0) ? 7'h24 : (k == 1) ? 7'h79 : 7'h7F;
      for (int c = 0; c < SD; c++) begin
        n_checks++;
        if ({ds, num, dp} !== {~(8'd1 << k), en_exp, 1'b1}) begin
          n_fail++;
          $display("[TB] FAIL display_digit%0d: got DS=%h num=%h dp=%b, want DS=%h num=%h dp=1",
                   k, ds, num, dp, ~(8'd1 << k), en_exp);
        end
        step();
      end
    end
  endtask

  task automatic test_load_mid_frame();
    int w;
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1; load = 1'b1; data_in = 32'h12; step(); load = 1'b0;
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    step();
    for (int c = 0; c < 2 * SD; c++) begin
      n_checks++;
      if ({ds, num} !== {(c < SD) ? 8'hFE : 8'hFD, (c < SD) ? 7'h24 : 7'h79}) begin
        n_fail++;
        $display("[TB] FAIL midload_old_c%0d: got DS=%h num=%h, want old frame contents", c, ds, num);
      end
      if (c == 0) begin load = 1'b1; data_in = 32'h99; end
      step();
      load = 1'b0;
    end
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midload_wait: got fd=%b, want 1", frame_done);
    end
    step();
    for (int c = 0; c < 2 * SD; c++) begin
      n_checks++;
      if ({ds, num} !== {(c < SD) ? 8'hFE : 8'hFD, 7'h10}) begin
        n_fail++;
        $display("[TB] FAIL midload_new_c%0d: got DS=%h num=%h, want num=10", c, ds, num);
      end
      step();
    end
  endtask

  task automatic test_enable();
    logic [6:0] e_num;
    logic       e_dp;
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1;
    repeat (6) step();
    en_all = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin load = 1'b1; data_in = 32'h5; dp_in = 8'h01; end
      step();
      load = 1'b0;
      n_checks++;
      if ({ds, num, dp, scan_tick, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL disable_dark_c%0d: got DS=%h num=%h dp=%b tick=%b fd=%b, want ff 7f 1 0 0",
                 c, ds, num, dp, scan_tick, frame_done);
      end
    end
    dp_in = '0;
    en_all = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      e_num = (c == 0) ? 7'h40 : (c < 4) ? 7'h12 : 7'h7F;
      e_dp  = (c == 0 || c == 4);
      n_checks++;
      if ({ds, num, dp} !== {(c < 4) ? 8'hFE : 8'hFD, e_num, e_dp}) begin
        n_fail++;
        $display("[TB] FAIL reenable_c%0d: got DS=%h num=%h dp=%b, want num=%h dp=%b", c, ds, num, dp,
                 e_num, e_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1; load = 1'b1; data_in = 32'h12; step(); load = 1'b0;
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    w = 0;
    while (ds !== 8'hDF && w < FR) begin step(); w++; end
    n_checks++;
    if (ds !== 8'hDF) begin
      n_fail++; $display("[TB] FAIL rstmid_reach_idx5: got DS=%h, want df", ds);
    end
    rst = 1'b1; step();
    n_checks++;
    if ({ds, num, dp, scan_tick, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rstmid_dark: got DS=%h num=%h dp=%b, want ff 7f 1", ds, num, dp);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({ds, num} !== {(c < 4) ? 8'hFE : 8'hFD, (c < 4) ? 7'h40 : 7'h7F}) begin
        n_fail++;
        $display("[TB] FAIL rstmid_restart_c%0d: got DS=%h num=%h", c, ds, num);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1; step();
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    load = 1'b1; data_in = 32'h2; step(); load = 1'b0;
    repeat (FR - 2) step();
    load = 1'b1; data_in = 32'h1; step(); load = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_wrap_align: got fd=%b, want 1", frame_done);
    end
    step();
    n_checks++;
    if ({ds, num} !== {8'hFE, 7'h24} || {ds, num} !== {exp_ds, exp_num}) begin
      n_fail++;
      $display("[TB] FAIL b2b_frame1: got DS=%h num=%h, want fe 24 (model %h %h)", ds, num, exp_ds, exp_num);
    end
    w = 0;
    while (frame_done !== 1'b1 && w < 2 * FR) begin step(); w++; end
    step();
    n_checks++;
    if ({ds, num} !== {8'hFE, 7'h79} || {ds, num} !== {exp_ds, exp_num}) begin
      n_fail++;
      $display("[TB] FAIL b2b_frame2: got DS=%h num=%h, want fe 79 (model %h %h)", ds, num, exp_ds, exp_num);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; step();
    rst = 1'b0; en_all = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (en_all) en_all = ($urandom_range(0, 149) != 0);
      else        en_all = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 15) == 0);
      data_in = $urandom >> ($urandom_range(0, 7) * 4);
      dp_in   = 8'($urandom);
      step();
      n_checks++;
      if ({num, dp, ds, scan_tick, frame_done} !== {exp_num, exp_dp, exp_ds, exp_tick, exp_fd}) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got %h/%b/%h/%b/%b, want %h/%b/%h/%b/%b", i,
                 num, dp, ds, scan_tick, frame_done, exp_num, exp_dp, exp_ds, exp_tick, exp_fd);
      end
    end
    rst = 1'b0; load = 1'b0; dp_in = '0;
  endtask

  task automatic test_small_config();
    en_all = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; en2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if ({ds2, num2, dp2, tick2, fd2} !== {~(4'd1 << (k % 4)), 7'h40, 1'b1, 1'b1, (k % 4 == 3)}) begin
        n_fail++;
        $display("[TB] FAIL small_cfg_c%0d: got DS=%h num=%h dp=%b tick=%b fd=%b, want DS=%h num=40",
                 k, ds2, num2, dp2, tick2, fd2, ~(4'd1 << (k % 4)));
      end
    end
    en2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_all = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    en2 = 1'b0; load2 = 1'b0; data2 = '0; dp2_in = '0;
    test_reset();
    test_display();
    test_load_mid_frame();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
